// File: rtl/led_scan_pkg.sv
// Shared definitions for the LED matrix / 7-segment scan controller:
// scan FSM states, default timing parameters and a frame row helper.
package led_scan_pkg;

    localparam int SCAN_DIV_DEF  = 50000;
    localparam int BLANK_CYC_DEF = 16;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_t;

    // Row r of a frame occupies bits [8r+7:8r].
    function automatic logic [7:0] row_of(input logic [63:0] frame, input logic [2:0] row);
        return frame[{row, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running row-period prescaler: counts 0..SCAN_DIV-1 and flags the wrap
// cycle with a one-cycle tick.
module scan_prescaler
    import led_scan_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/led_scan_ctrl.sv
// 8x8 LED matrix row scanner with double-buffered frames and blanking,
// plus a frame-synchronous selector between two 7-segment sources.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [7:0]  seg_a,
    input  logic [3:0]  com_a,
    input  logic [7:0]  seg_b,
    input  logic [3:0]  com_b,
    input  logic        src_sel,
    output logic [7:0]  data_r,
    output logic [2:0]  s,
    output logic        en,
    output logic [7:0]  seg,
    output logic [3:0]  com,
    output logic        frame_start
);

    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

    logic tick;

    scan_prescaler #(
        .SCAN_DIV(SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    scan_state_t   state, state_next;
    logic [BW-1:0] blank_cnt, blank_cnt_next;
    logic [2:0]    s_next;
    logic          wrap;
    logic [63:0]   active, active_next;
    logic [63:0]   pending;
    logic          pending_full, pending_full_next;
    logic          accept;
    logic [7:0]    data_r_next;
    logic          sync1, sync2, sel;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        blank_cnt_next = '0;
        s_next         = s;
        wrap           = 1'b0;

        case (state)
            ST_DRIVE: begin
                if (tick) begin
                    state_next = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    state_next = ST_DRIVE;
                    s_next     = s + 3'd1;
                    wrap       = (s == 3'd7);
                end else begin
                    blank_cnt_next = blank_cnt + BW'(1);
                end
            end
            default: state_next = ST_DRIVE;
        endcase
    end

    // Frame handshake; acceptance and swap can coincide only with pending
    // empty, in which case the new frame waits for the following wrap.
    always_comb begin
        accept            = frame_valid && frame_ready;
        active_next       = (wrap && pending_full) ? pending : active;
        pending_full_next = pending_full;
        if (accept) begin
            pending_full_next = 1'b1;
        end else if (wrap) begin
            pending_full_next = 1'b0;
        end
    end

    // data_r is registered from next-cycle state so it already matches the
    // row on the first cycle of each drive window.
    always_comb begin
        data_r_next = 8'hFF;
        if (state_next == ST_DRIVE) begin
            data_r_next = ~row_of(active_next, s_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_DRIVE;
            blank_cnt   <= '0;
            s           <= 3'd0;
            data_r      <= 8'hFF;
            frame_start <= 1'b0;
            frame_ready <= 1'b0;
            en          <= 1'b0;
        end else begin
            state       <= state_next;
            blank_cnt   <= blank_cnt_next;
            s           <= s_next;
            data_r      <= data_r_next;
            frame_start <= wrap;
            frame_ready <= !pending_full_next;
            en          <= 1'b1;
        end
    end

    // NOTE: the frame buffers are reset on purpose: a frame held across reset
    // must never reappear on the matrix afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            active       <= active_next;
            pending_full <= pending_full_next;
            if (accept) begin
                pending <= frame_in;
            end
        end
    end

    // Source select is synchronized, then only adopted at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sel   <= 1'b0;
            seg   <= 8'h00;
            com   <= 4'h0;
        end else begin
            sync1 <= src_sel;
            sync2 <= sync1;
            if (wrap) begin
                sel <= sync2;
            end
            seg <= sel ? seg_a : seg_b;
            com <= sel ? com_a : com_b;
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with SCAN_DIV=10, BLANK_CYC=2: row i drives
// cycles 10i+2..10i+9 (frame-relative), wraps land on cycles 82, 162, 242.
module tb_led_scan_ctrl;

    localparam int SCAN_DIV  = 10;
    localparam int BLANK_CYC = 2;

    logic        clk;
    logic        rst_n;
    logic [63:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  seg_a, seg_b, seg;
    logic [3:0]  com_a, com_b, com;
    logic        src_sel;
    logic [7:0]  data_r;
    logic [2:0]  s;
    logic        en;
    logic        frame_start;

    led_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .seg_a      (seg_a),
        .com_a      (com_a),
        .seg_b      (seg_b),
        .com_b      (com_b),
        .src_sel    (src_sel),
        .data_r     (data_r),
        .s          (s),
        .en         (en),
        .seg        (seg),
        .com        (com),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n = state visible after the n-th rising edge since reset release.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [2:0] s;
        logic [7:0] d;
        logic       fs;
        logic       fr;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] FRAME_DIAG = 64'h0102040810204080;
    localparam logic [63:0] FRAME_AA   = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] FRAME_55   = 64'h5555_5555_5555_5555;
    localparam logic [63:0] FRAME_X    = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] FRAME_Y    = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [63:0] FRAME_Z    = 64'h1234_5678_9ABC_DEF0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc != n && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc: cycle %0d not reached (at %0d)", n, cyc);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        wait_cyc(v.cyc);
        check($sformatf("%s@%0d s", tag, v.cyc), 64'(s), 64'(v.s));
        check($sformatf("%s@%0d data_r", tag, v.cyc), 64'(data_r), 64'(v.d));
        check($sformatf("%s@%0d frame_start", tag, v.cyc), 64'(frame_start), 64'(v.fs));
        check($sformatf("%s@%0d frame_ready", tag, v.cyc), 64'(frame_ready), 64'(v.fr));
        check($sformatf("%s@%0d en", tag, v.cyc), 64'(en), 64'(v.cyc >= 1));
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tag, tbl[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s"}, 64'(s), 64'(3'd0));
        check({tag, " data_r"}, 64'(data_r), 64'(8'hFF));
        check({tag, " en"}, 64'(en), 64'(1'b0));
        check({tag, " seg"}, 64'(seg), 64'(8'h00));
        check({tag, " com"}, 64'(com), 64'(4'h0));
        check({tag, " frame_start"}, 64'(frame_start), 64'(1'b0));
        check({tag, " frame_ready"}, 64'(frame_ready), 64'(1'b0));
    endtask

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic offer(input int at, input logic [63:0] f);
        wait_cyc(at);
        frame_in    = f;
        frame_valid = 1'b1;
        wait_cyc(at + 1);
        frame_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        frame_in    = '0;
        frame_valid = 1'b0;
        seg_a       = 8'h3F;
        com_a       = 4'hA;
        seg_b       = 8'h06;
        com_b       = 4'h5;
        src_sel     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Idle scan: blank frame, row walk, frame_start every 80 cycles.
        tbl = '{'{0, 3'd0, 8'hFF, 1'b0, 1'b0}, '{1, 3'd0, 8'hFF, 1'b0, 1'b1},
                '{9, 3'd0, 8'hFF, 1'b0, 1'b1}, '{10, 3'd0, 8'hFF, 1'b0, 1'b1},
                '{11, 3'd0, 8'hFF, 1'b0, 1'b1}, '{12, 3'd1, 8'hFF, 1'b0, 1'b1},
                '{21, 3'd1, 8'hFF, 1'b0, 1'b1}, '{22, 3'd2, 8'hFF, 1'b0, 1'b1},
                '{72, 3'd7, 8'hFF, 1'b0, 1'b1}, '{81, 3'd7, 8'hFF, 1'b0, 1'b1},
                '{82, 3'd0, 8'hFF, 1'b1, 1'b1}, '{83, 3'd0, 8'hFF, 1'b0, 1'b1},
                '{92, 3'd1, 8'hFF, 1'b0, 1'b1}, '{161, 3'd7, 8'hFF, 1'b0, 1'b1},
                '{162, 3'd0, 8'hFF, 1'b1, 1'b1}};
        run_table("idle");

        // Diagonal frame accepted mid-frame; shown from the next wrap only.
        restart();
        tbl = '{'{30, 3'd2, 8'hFF, 1'b0, 1'b1}, '{31, 3'd2, 8'hFF, 1'b0, 1'b0},
                '{55, 3'd5, 8'hFF, 1'b0, 1'b0}, '{81, 3'd7, 8'hFF, 1'b0, 1'b0},
                '{82, 3'd0, 8'h7F, 1'b1, 1'b1}, '{89, 3'd0, 8'h7F, 1'b0, 1'b1},
                '{90, 3'd0, 8'hFF, 1'b0, 1'b1}, '{91, 3'd0, 8'hFF, 1'b0, 1'b1},
                '{92, 3'd1, 8'hBF, 1'b0, 1'b1}, '{105, 3'd2, 8'hDF, 1'b0, 1'b1},
                '{115, 3'd3, 8'hEF, 1'b0, 1'b1}, '{125, 3'd4, 8'hF7, 1'b0, 1'b1},
                '{135, 3'd5, 8'hFB, 1'b0, 1'b1}, '{145, 3'd6, 8'hFD, 1'b0, 1'b1},
                '{155, 3'd7, 8'hFE, 1'b0, 1'b1}, '{162, 3'd0, 8'h7F, 1'b1, 1'b1}};
        fork
            offer(30, FRAME_DIAG);
            run_table("diag");
        join

        // Back-to-back frames: second held off until the first is swapped in.
        restart();
        tbl = '{'{21, 3'd1, 8'hFF, 1'b0, 1'b0}, '{40, 3'd3, 8'hFF, 1'b0, 1'b0},
                '{81, 3'd7, 8'hFF, 1'b0, 1'b0}, '{82, 3'd0, 8'h55, 1'b1, 1'b1},
                '{83, 3'd0, 8'h55, 1'b0, 1'b0}, '{155, 3'd7, 8'h55, 1'b0, 1'b0},
                '{159, 3'd7, 8'h55, 1'b0, 1'b0}, '{162, 3'd0, 8'hAA, 1'b1, 1'b1},
                '{165, 3'd0, 8'hAA, 1'b0, 1'b1}, '{235, 3'd7, 8'hAA, 1'b0, 1'b1}};
        fork
            begin
                wait_cyc(20);
                frame_in    = FRAME_AA;
                frame_valid = 1'b1;
                wait_cyc(21);
                frame_in    = FRAME_55;
                wait_cyc(83);
                frame_valid = 1'b0;
            end
            run_table("b2b");
        join

        // Frame offered exactly in the wrap cycle: old frame shown once more.
        restart();
        tbl = '{'{82, 3'd0, 8'hF0, 1'b1, 1'b1}, '{161, 3'd7, 8'hFF, 1'b0, 1'b1},
                '{162, 3'd0, 8'hF0, 1'b1, 1'b0}, '{165, 3'd0, 8'hF0, 1'b0, 1'b0},
                '{239, 3'd7, 8'hF0, 1'b0, 1'b0}, '{242, 3'd0, 8'h0F, 1'b1, 1'b1},
                '{245, 3'd0, 8'h0F, 1'b0, 1'b1}};
        fork
            begin
                offer(30, FRAME_X);
                offer(161, FRAME_Y);
            end
            run_table("wrapacc");
        join

        // Source select: adopted only at the frame wrap, seg latency 1 cycle.
        restart();
        wait_cyc(0);
        check("sel@0 seg", 64'(seg), 64'(8'h00));
        wait_cyc(1);
        check("sel@1 seg", 64'(seg), 64'(8'h06));
        check("sel@1 com", 64'(com), 64'(4'h5));
        wait_cyc(20);
        seg_b = 8'h5B;
        check("sel@20 seg", 64'(seg), 64'(8'h06));
        wait_cyc(21);
        check("sel@21 seg", 64'(seg), 64'(8'h5B));
        seg_b = 8'h06;
        wait_cyc(22);
        check("sel@22 seg", 64'(seg), 64'(8'h06));
        wait_cyc(35);
        src_sel = 1'b1;
        wait_cyc(40);
        check("sel@40 seg", 64'(seg), 64'(8'h06));
        wait_cyc(81);
        check("sel@81 seg", 64'(seg), 64'(8'h06));
        check("sel@81 com", 64'(com), 64'(4'h5));
        wait_cyc(82);
        check("sel@82 seg", 64'(seg), 64'(8'h06));
        wait_cyc(86);
        check("sel@86 seg", 64'(seg), 64'(8'h3F));
        check("sel@86 com", 64'(com), 64'(4'hA));
        src_sel = 1'b0;

        // Reset in row 5 blank with a frame pending: nothing survives.
        restart();
        tbl = '{'{85, 3'd0, 8'hF0, 1'b0, 1'b1}, '{91, 3'd0, 8'hFF, 1'b0, 1'b0},
                '{140, 3'd5, 8'hFF, 1'b0, 1'b0}};
        fork
            begin
                offer(30, FRAME_X);
                offer(90, FRAME_Z);
            end
            run_table("prerst");
        join
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tbl = '{'{0, 3'd0, 8'hFF, 1'b0, 1'b0}, '{1, 3'd0, 8'hFF, 1'b0, 1'b1},
                '{5, 3'd0, 8'hFF, 1'b0, 1'b1}, '{82, 3'd0, 8'hFF, 1'b1, 1'b1},
                '{85, 3'd0, 8'hFF, 1'b0, 1'b1}, '{92, 3'd1, 8'hFF, 1'b0, 1'b1}};
        run_table("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
